// File: rtl/temporal_ngram_encoder.sv
// Temporal N-gram encoder: binds each accepted spatial hypervector with its
// age-permuted predecessors and hands one N-gram per sample downstream.
module temporal_ngram_encoder #(
  parameter int HV_DIMENSION = 2000,
  parameter int NGRAM_SIZE   = 3
) (
  input  logic                    Clk_CI,
  input  logic                    Reset_RI,
  input  logic                    ValidIn_SI,
  output logic                    ReadyOut_SO,
  input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
  input  logic                    ClearHistory_SI,
  output logic                    ValidOut_SO,
  input  logic                    ReadyIn_SI,
  output logic [0:HV_DIMENSION-1] NGramOut_DO,
  output logic                    HistoryFull_SO
);

  localparam bit SINGLE   = (NGRAM_SIZE == 1);
  localparam int NUM_HIST = SINGLE ? 1 : NGRAM_SIZE - 1;
  localparam int CNT_W    = SINGLE ? 1 : $clog2(NGRAM_SIZE);

  typedef enum logic {EMPTY, FULL} out_state_e;

  out_state_e              state_q, state_d;
  logic                    accept;
  logic                    gen_output;
  logic [0:HV_DIMENSION-1] bind_d;

  // Index k moves to k+1; the last index wraps around to index 0.
  function automatic logic [0:HV_DIMENSION-1] rho(input logic [0:HV_DIMENSION-1] v);
    return {v[HV_DIMENSION-1], v[0:HV_DIMENSION-2]};
  endfunction

  assign ReadyOut_SO = Reset_RI && (!ValidOut_SO || ReadyIn_SI);
  assign accept      = ValidIn_SI && ReadyOut_SO;

  // A clear coinciding with an accept starts a fresh sequence, so only the
  // degenerate single-sample N-gram can still produce an output then.
  assign gen_output  = accept && (SINGLE || (HistoryFull_SO && !ClearHistory_SI));

  generate
    if (SINGLE) begin : g_no_history
      assign HistoryFull_SO = 1'b1;
      assign bind_d         = HypervectorIn_DI;
    end else begin : g_history
      logic [0:HV_DIMENSION-1] hist_q [NUM_HIST];
      logic [CNT_W-1:0]        fill_q;

      assign HistoryFull_SO = (fill_q == CNT_W'(NGRAM_SIZE - 1));

      // History is kept pre-permuted so the bind is a flat XOR of all taps.
      always_ff @(posedge Clk_CI) begin
        if (!Reset_RI) begin
          fill_q <= '0;
          for (int i = 0; i < NUM_HIST; i++) hist_q[i] <= '0;
        end else if (ClearHistory_SI) begin
          fill_q <= '0;
          for (int i = 0; i < NUM_HIST; i++) hist_q[i] <= '0;
          if (accept) begin
            hist_q[0] <= rho(HypervectorIn_DI);
            fill_q    <= CNT_W'(1);
          end
        end else if (accept) begin
          hist_q[0] <= rho(HypervectorIn_DI);
          for (int i = 1; i < NUM_HIST; i++) hist_q[i] <= rho(hist_q[i-1]);
          if (!HistoryFull_SO) fill_q <= fill_q + CNT_W'(1);
        end
      end

      always_comb begin
        bind_d = HypervectorIn_DI;
        for (int i = 0; i < NUM_HIST; i++) bind_d = bind_d ^ hist_q[i];
      end
    end
  endgenerate

  always_ff @(posedge Clk_CI) begin
    if (!Reset_RI) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (gen_output) state_d = FULL;
      FULL:    if (!gen_output && ReadyIn_SI) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    ValidOut_SO = (state_q == FULL);
  end

  always_ff @(posedge Clk_CI) begin
    if (!Reset_RI) begin
      NGramOut_DO <= '0;
    end else if (gen_output) begin
      NGramOut_DO <= bind_d;
    end
  end

endmodule

// File: tb/tb_temporal_ngram_encoder.sv
// Directed and random bench for temporal_ngram_encoder (8-bit HV, trigrams),
// with a reference model feeding an expected-output scoreboard queue.
module tb_temporal_ngram_encoder;

  localparam int W = 8;

  logic         Clk_CI = 1'b0;
  logic         Reset_RI = 1'b0;
  logic         ValidIn_SI = 1'b0;
  logic         ReadyOut_SO;
  logic [0:W-1] HypervectorIn_DI = '0;
  logic         ClearHistory_SI = 1'b0;
  logic         ValidOut_SO;
  logic         ReadyIn_SI = 1'b0;
  logic [0:W-1] NGramOut_DO;
  logic         HistoryFull_SO;

  int vectors = 0;
  int miscompares = 0;

  logic [0:W-1] exp_q [$];
  logic [0:W-1] m_h1 = '0;
  logic [0:W-1] m_h2 = '0;
  int           m_count = 0;
  logic         m_valid = 1'b0;

  temporal_ngram_encoder #(.HV_DIMENSION(W), .NGRAM_SIZE(3)) dut (
    .Clk_CI           (Clk_CI),
    .Reset_RI         (Reset_RI),
    .ValidIn_SI       (ValidIn_SI),
    .ReadyOut_SO      (ReadyOut_SO),
    .HypervectorIn_DI (HypervectorIn_DI),
    .ClearHistory_SI  (ClearHistory_SI),
    .ValidOut_SO      (ValidOut_SO),
    .ReadyIn_SI       (ReadyIn_SI),
    .NGramOut_DO      (NGramOut_DO),
    .HistoryFull_SO   (HistoryFull_SO)
  );

  always #5 Clk_CI = ~Clk_CI;

  function automatic logic [0:W-1] model_rho(input logic [0:W-1] v);
    logic [0:W-1] r;
    for (int k = 0; k < W; k++) r[(k + 1) % W] = v[k];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drives one cycle, checks outputs mid-cycle, then advances the model
  // through the coming rising edge.
  task automatic applyStimulus(input logic valid, input logic [0:W-1] data,
                               input logic ready, input logic clear, input logic rst);
    logic exp_ready, accept, full_before, gen;
    ValidIn_SI       = valid;
    HypervectorIn_DI = data;
    ReadyIn_SI       = ready;
    ClearHistory_SI  = clear;
    Reset_RI         = rst;
    @(negedge Clk_CI);
    exp_ready = rst && (!m_valid || ready);
    checkOutput("ready_out", {7'b0, ReadyOut_SO}, {7'b0, exp_ready});
    checkOutput("hist_full", {7'b0, HistoryFull_SO}, {7'b0, m_count == 2});
    checkOutput("valid_out", {7'b0, ValidOut_SO}, {7'b0, m_valid});
    if (m_valid && exp_q.size() > 0) checkOutput("ngram_out", NGramOut_DO, exp_q[0]);
    accept = valid && exp_ready;
    if (!rst) begin
      exp_q.delete();
      m_valid = 1'b0;
      m_h1 = '0;
      m_h2 = '0;
      m_count = 0;
    end else begin
      full_before = (m_count == 2);
      gen = accept && full_before && !clear;
      if (m_valid && ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (gen) exp_q.push_back(data ^ m_h1 ^ m_h2);
      if (gen) m_valid = 1'b1;
      else if (ready) m_valid = 1'b0;
      if (clear) begin
        m_h2 = '0;
        m_h1 = accept ? model_rho(data) : '0;
        m_count = accept ? 1 : 0;
      end else if (accept) begin
        m_h2 = model_rho(m_h1);
        m_h1 = model_rho(data);
        if (m_count < 2) m_count++;
      end
    end
    @(posedge Clk_CI);
    #1;
  endtask

  initial begin
    logic [0:W-1] v;
    // Reset values
    Reset_RI = 1'b0;
    repeat (2) @(posedge Clk_CI);
    #1;
    checkOutput("rst_valid", {7'b0, ValidOut_SO}, 8'd0);
    checkOutput("rst_ngram", NGramOut_DO, 8'd0);
    checkOutput("rst_full", {7'b0, HistoryFull_SO}, 8'd0);
    checkOutput("rst_ready", {7'b0, ReadyOut_SO}, 8'd0);

    // Warm-up and bind: expect 11100000 after third accept
    repeat (3) applyStimulus(1, 8'b10000000, 1, 0, 1);
    checkOutput("warmup_bind", NGramOut_DO, 8'b11100000);
    applyStimulus(0, '0, 1, 1, 1);

    // Wrap-around
    repeat (3) applyStimulus(1, 8'b00000001, 1, 0, 1);
    checkOutput("wrap_bind", NGramOut_DO, 8'b11000001);
    applyStimulus(0, '0, 1, 1, 1);

    // Streaming one-hot vectors back to back
    v = 8'b10000000;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, v, 1, 0, 1);
      v = v >> 1;
    end
    checkOutput("stream_last", NGramOut_DO, 8'b00000100);

    // Backpressure with a pending output
    repeat (4) applyStimulus(1, 8'b00000010, 0, 0, 1);
    applyStimulus(1, 8'b00000010, 1, 0, 1);
    applyStimulus(0, '0, 1, 0, 1);

    // Clear coincident with accept
    applyStimulus(1, 8'b10000000, 1, 1, 1);
    repeat (2) applyStimulus(1, 8'b10000000, 1, 0, 1);
    checkOutput("clear_seq", NGramOut_DO, 8'b11100000);

    // Reset mid-stream while an output is pending
    applyStimulus(0, '0, 0, 0, 1);
    applyStimulus(0, '0, 0, 0, 0);
    checkOutput("midrst_valid", {7'b0, ValidOut_SO}, 8'd0);
    checkOutput("midrst_ngram", NGramOut_DO, 8'd0);
    checkOutput("midrst_full", {7'b0, HistoryFull_SO}, 8'd0);
    repeat (3) applyStimulus(1, 8'b01000000, 1, 0, 1);
    applyStimulus(0, '0, 1, 0, 1);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 9) == 0), 1);
    end
    repeat (2) applyStimulus(0, '0, 1, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/temporal_ngram_encoder.md
# temporal_ngram_encoder

Temporal N-gram encoder sitting directly downstream of the spatial encoder. It accepts one spatial hypervector per sample over a valid/ready handshake and binds it with the previous NGRAM_SIZE-1 accepted hypervectors, each permuted by its age. It emits one N-gram hypervector per accepted sample once the history is full. Its output feeds the associative-memory stage.

## Interface
- HV_DIMENSION, default 2000: hypervector width in bits.
- NGRAM_SIZE, default 3: N-gram length; legal range 1..8.
- Clk_CI  input  1  single clock; all state updates on the rising edge.
- Reset_RI  input  1  reset, synchronous and active-low.
- ValidIn_SI  input  1  upstream hypervector valid.
- ReadyOut_SO  output  1  this block can accept a hypervector.
- HypervectorIn_DI  input  [0:HV_DIMENSION-1]  spatial hypervector.
- ClearHistory_SI  input  1  start a new sequence (trial boundary); single-cycle pulse.
- ValidOut_SO  output  1  N-gram output valid.
- ReadyIn_SI  input  1  downstream ready.
- NGramOut_DO  output  [0:HV_DIMENSION-1]  N-gram hypervector (registered).
- HistoryFull_SO  output  1  fill count equals NGRAM_SIZE-1.

## Operation
- Accept condition: ValidIn_SI && ReadyOut_SO.
- Permutation rho: circular shift by one index. Bit k moves to k+1, and bit HV_DIMENSION-1 wraps to bit 0.
- History: NGRAM_SIZE-1 registers H1..H(N-1), stored pre-permuted.
  - On accept: H1 <= rho(X); Hi <= rho(H(i-1)) for i >= 2.
  - Hi therefore holds the vector accepted i samples ago, permuted i times.
- Bind: N-gram = X XOR H1 XOR ... XOR H(N-1). This is a pure bitwise XOR with no width growth.
- Fill counter: saturating, 0..NGRAM_SIZE-1.
  - Increments on each accept while below NGRAM_SIZE-1.
  - HistoryFull_SO = (count == NGRAM_SIZE-1).
- Output generation: an accept with HistoryFull_SO=1 (count sampled before the accept) loads NGramOut_DO and sets ValidOut_SO.
  - Accepts made during warm-up update the history and counter only; they produce no output.
  - With NGRAM_SIZE=1 there are no history registers, HistoryFull_SO is constant 1, and every accept outputs X unchanged.
- Output FSM states:
  - EMPTY (ValidOut_SO=0) -> FULL on an output-generating accept.
  - FULL (ValidOut_SO=1) -> EMPTY on ReadyIn_SI with no output-generating accept.
  - FULL stays FULL and reloads NGramOut_DO on ReadyIn_SI together with an output-generating accept.
  - FULL holds on !ReadyIn_SI.
- ReadyOut_SO = Reset_RI && (!ValidOut_SO || ReadyIn_SI). This is combinational, giving full throughput with no bubble.
- ClearHistory_SI: zeroes H1..H(N-1) and the fill counter. An output already in FULL is unaffected.
- Clear coincident with accept: clear takes priority, and the accepted vector becomes sample 0 of the new sequence.
  - H1 <= rho(X), all other Hi <= 0, count <= 1 (saturating at NGRAM_SIZE-1).
  - An output is generated only if NGRAM_SIZE=1.
- Backpressure: while no accept occurs, history, counter and NGramOut_DO are held.

## Timing
- Reset values (Reset_RI=0 at a clock edge):
  - ValidOut_SO=0, NGramOut_DO=0, HistoryFull_SO=0 (1 if NGRAM_SIZE=1).
  - All Hi=0, count=0, state EMPTY.
  - ReadyOut_SO=0 while Reset_RI=0.
- Reset mid-operation discards any pending output and all history. The first accept after reset starts a new sequence.
- Latency: ValidOut_SO rises one cycle after the output-generating accept edge.
- Throughput: one hypervector per cycle when ReadyIn_SI is held high.
- First output after reset or clear occurs on the NGRAM_SIZE-th accept.
- NGramOut_DO is stable whenever ValidOut_SO=1 && ReadyIn_SI=0.

## Test plan
All scenarios use HV_DIMENSION=8 and NGRAM_SIZE=3. Literals are written index 0 leftmost.

- Warm-up and bind: accept 8'b10000000 three times with ReadyIn_SI=1 -> no output after accepts 1 and 2; after accept 3, ValidOut_SO=1 and NGramOut_DO=8'b11100000.
- Wrap-around: accept 8'b00000001 three times -> NGramOut_DO=8'b11000001.
- Streaming: 6 back-to-back accepts of 8'b10000000, 8'b01000000, 8'b00100000, ... -> outputs on accepts 3..6, each 8'b00100000, 8'b00010000, ... XOR-correct (rho aligns all three to the same bit, so a single set bit remains). ReadyOut_SO never drops.
- Backpressure: hold ReadyIn_SI=0 with ValidOut_SO=1 and ValidIn_SI=1 for 4 cycles -> ReadyOut_SO=0, NGramOut_DO and history unchanged. Releasing ReadyIn_SI produces the next output one cycle later.
- Clear with accept: pulse ClearHistory_SI with an accept of 8'b10000000 -> HistoryFull_SO=0, count=1, no output. Two further accepts produce the first output of the new sequence.
- Reset mid-stream: drive Reset_RI=0 for one cycle while in FULL -> ValidOut_SO=0, NGramOut_DO=0, HistoryFull_SO=0. Three more accepts are required before the next output.
